sdram_arbiter_n: RTL and testbench

//  N-port SDRAM arbiter; next generation of the two-port CPU/video arbiter.

---
 rtl/sdram_arbiter_n_if.sv | 58 +++++
 rtl/sdram_arbiter_n.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_sdram_arbiter_n.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_n_if
// Description : Bus bundle for the N-port SDRAM arbiter. Carries the requester
//               command/response signals and the single controller-side
//               command/response channel.
//   slave  modport : arbiter view (requester commands in, controller
//                    responses in, grants/strobes/controller command out)
//   master modport : environment view (requesters + SDRAM controller)
// Revision    : 1.0  initial release
// ============================================================================
interface sdram_arbiter_n_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24
);
  // requester side
  logic [NUM_PORTS-1:0]        port_cmd_valid_i;
  logic [NUM_PORTS-1:0]        port_cmd_ready_o;
  logic [NUM_PORTS-1:0]        port_rd_i;
  logic [NUM_PORTS-1:0]        port_wr_i;
  logic [NUM_PORTS-1:0]        port_burst_i;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr_x16_i;
  logic [NUM_PORTS*16-1:0]     port_wdata_i;
  logic [NUM_PORTS*2-1:0]      port_wmask_i;
  logic [NUM_PORTS-1:0]        port_resp_valid_o;
  logic [15:0]                 port_rdata_o;

  // controller side
  logic                        sdram_cmd_valid;
  logic                        sdram_cmd_ready;
  logic                        sdram_rd;
  logic                        sdram_wr;
  logic                        sdram_burst;
  logic [ADDR_W-1:0]           sdram_addr_x16;
  logic [15:0]                 sdram_wdata;
  logic [1:0]                  sdram_wmask;
  logic                        sdram_resp_valid;
  logic [15:0]                 sdram_rdata;

  modport slave (
    input  port_cmd_valid_i, port_rd_i, port_wr_i, port_burst_i,
           port_addr_x16_i, port_wdata_i, port_wmask_i,
           sdram_cmd_ready, sdram_resp_valid, sdram_rdata,
    output port_cmd_ready_o, port_resp_valid_o, port_rdata_o,
           sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst,
           sdram_addr_x16, sdram_wdata, sdram_wmask
  );

  modport master (
    output port_cmd_valid_i, port_rd_i, port_wr_i, port_burst_i,
           port_addr_x16_i, port_wdata_i, port_wmask_i,
           sdram_cmd_ready, sdram_resp_valid, sdram_rdata,
    input  port_cmd_ready_o, port_resp_valid_o, port_rdata_o,
           sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst,
           sdram_addr_x16, sdram_wdata, sdram_wmask
  );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_n
// Description : N-port SDRAM command arbiter with in-order read response
//               routing. Fixed-priority (port 0 highest) or round-robin
//               selection; accepted reads push a {burst, port id} tag into a
//               FIFO and returning beats are steered to the port at its head.
//               Command and response paths are purely combinational.
// Ports       : clk_i    system clock
//               rst_n_i  synchronous reset, active low
//               bus      sdram_arbiter_n_if.slave (requester + controller side)
//               err_o    sticky: read beat arrived with no tag outstanding
// Options     : define SDRAM_ARB_AGING_EN to add per-port wait counters; a
//               port waiting AGE_LIMIT cycles overrides normal selection.
// Parameters  : NUM_PORTS 2..8, MAX_OUTSTANDING power of 2 (>= 2),
//               BURST_LEN >= 2.
// Revision    : 1.0  initial release
// ============================================================================
module sdram_arbiter_n #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_W          = 24,
  parameter int PRIO_MODE       = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BURST_LEN       = 4,
  parameter int AGE_LIMIT       = 64
) (
  input  wire logic         clk_i,
  input  wire logic         rst_n_i,
  sdram_arbiter_n_if.slave  bus,
  output logic              err_o
);

  localparam int IDW = $clog2(NUM_PORTS);
  localparam int FAW = $clog2(MAX_OUTSTANDING);
  localparam int CW  = FAW + 1;
  localparam int BW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  // Grant hold: once a command is presented and stalled, the same port keeps
  // the grant so the controller sees a stable payload until it accepts.
  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDW-1:0]       r_hold_id;
  logic [IDW-1:0]       w_hold_id_nxt;

  logic [IDW-1:0]       r_rr_ptr;
  logic                 r_err;

  // tag FIFO: each entry is {burst, port id}
  logic [IDW:0]         r_tag_mem [MAX_OUTSTANDING];
  logic [FAW-1:0]       r_wptr;
  logic [FAW-1:0]       r_rptr;
  logic [CW-1:0]        r_count;
  logic [BW-1:0]        r_beat;

  logic                 w_full;
  logic                 w_empty;
  logic [NUM_PORTS-1:0] w_elig;
  logic                 w_any;
  logic [IDW-1:0]       w_lo_id;
  logic [IDW-1:0]       w_hi_id;
  logic                 w_hi_found;
  logic [IDW-1:0]       w_gnt_id;
  logic                 w_gnt_rd;
  logic                 w_gnt_burst;
  logic                 w_accept;
  logic                 w_push;

  logic [IDW-1:0]       w_head_id;
  logic                 w_head_burst;
  logic                 w_beat;
  logic                 w_last;
  logic                 w_pop;

  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  // Anything that is not a read (including a bare valid) needs no tag slot.
  assign w_elig = bus.port_cmd_valid_i & (~bus.port_rd_i | {NUM_PORTS{~w_full}});
  assign w_any  = |w_elig;

  // ------------------------------------------------------------------------
  // Candidate scan. Walking from the top index down leaves the lowest match
  // in each candidate: overall lowest (fixed mode / RR wrap) and lowest at or
  // above the RR pointer.
  // ------------------------------------------------------------------------
  always_comb begin
    w_lo_id    = '0;
    w_hi_id    = '0;
    w_hi_found = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_id = IDW'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi_id    = IDW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
  end

`ifdef SDRAM_ARB_AGING_EN
  localparam int AGW = $clog2(AGE_LIMIT + 1);

  logic [AGW-1:0]       r_age [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_aged;
  logic [IDW-1:0]       w_aged_id;

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!rst_n_i) begin
        r_age[p] <= '0;
      end else if (w_accept && (int'(w_gnt_id) == p)) begin
        r_age[p] <= '0;
      end else if (bus.port_cmd_valid_i[p] && (r_age[p] != AGW'(AGE_LIMIT))) begin
        r_age[p] <= r_age[p] + AGW'(1);
      end
    end
  end

  always_comb begin
    w_aged    = '0;
    w_aged_id = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_elig[i] && (r_age[i] == AGW'(AGE_LIMIT))) begin
        w_aged[i] = 1'b1;
        w_aged_id = IDW'(i);
      end
    end
  end
`endif

  // Priority: held grant > aged port > normal policy.
  always_comb begin
    w_gnt_id = w_lo_id;
    if ((PRIO_MODE == 1) && w_hi_found) begin
      w_gnt_id = w_hi_id;
    end
`ifdef SDRAM_ARB_AGING_EN
    if (|w_aged) begin
      w_gnt_id = w_aged_id;
    end
`endif
    if ((r_state == ST_HOLD) && w_elig[r_hold_id]) begin
      w_gnt_id = r_hold_id;
    end
  end

  assign w_gnt_rd    = bus.port_rd_i[w_gnt_id];
  assign w_gnt_burst = bus.port_burst_i[w_gnt_id];
  assign w_accept    = w_any & bus.sdram_cmd_ready;
  assign w_push      = w_accept & w_gnt_rd;

  // ------------------------------------------------------------------------
  // Command path: payload is zero when nothing is granted. rd+wr together is
  // a read; burst only qualifies reads.
  // ------------------------------------------------------------------------
  always_comb begin
    bus.sdram_cmd_valid  = w_any;
    bus.sdram_rd         = 1'b0;
    bus.sdram_wr         = 1'b0;
    bus.sdram_burst      = 1'b0;
    bus.sdram_addr_x16   = '0;
    bus.sdram_wdata      = '0;
    bus.sdram_wmask      = '0;
    bus.port_cmd_ready_o = '0;
    if (w_any) begin
      bus.sdram_rd       = w_gnt_rd;
      bus.sdram_wr       = bus.port_wr_i[w_gnt_id] & ~w_gnt_rd;
      bus.sdram_burst    = w_gnt_rd & w_gnt_burst;
      bus.sdram_addr_x16 = bus.port_addr_x16_i[int'(w_gnt_id)*ADDR_W +: ADDR_W];
      bus.sdram_wdata    = bus.port_wdata_i[int'(w_gnt_id)*16 +: 16];
      bus.sdram_wmask    = bus.port_wmask_i[int'(w_gnt_id)*2 +: 2];
      bus.port_cmd_ready_o[w_gnt_id] = bus.sdram_cmd_ready;
    end
  end

  // ------------------------------------------------------------------------
  // Grant-hold FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_ARB;
      r_hold_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold_id <= w_hold_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = ST_ARB;
    w_hold_id_nxt = r_hold_id;
    if (w_any && !bus.sdram_cmd_ready) begin
      w_state_nxt   = ST_HOLD;
      w_hold_id_nxt = w_gnt_id;
    end
  end

  // Round-robin pointer moves just past the accepted port.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      if (w_gnt_id == IDW'(NUM_PORTS - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_gnt_id + IDW'(1);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Tag FIFO of outstanding reads
  // ------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag_mem[r_wptr] <= {w_gnt_burst, w_gnt_id};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + FAW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FAW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Response path: beats are steered to the head tag's port; a beat with no
  // tag outstanding is dropped and flagged.
  // ------------------------------------------------------------------------
  assign w_head_id    = r_tag_mem[r_rptr][IDW-1:0];
  assign w_head_burst = r_tag_mem[r_rptr][IDW];
  assign w_beat       = bus.sdram_resp_valid & ~w_empty;
  assign w_last       = ~w_head_burst | (r_beat == BW'(BURST_LEN - 1));
  assign w_pop        = w_beat & w_last;

  always_comb begin
    bus.port_resp_valid_o = '0;
    if (w_beat) begin
      bus.port_resp_valid_o[w_head_id] = 1'b1;
    end
  end

  assign bus.port_rdata_o = bus.sdram_rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_beat <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_beat <= '0;
      end else if (w_beat) begin
        r_beat <= r_beat + BW'(1);
      end
      if (bus.sdram_resp_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter_n
// Description : Self-checking bench for sdram_arbiter_n. One fixed-priority
//               and one round-robin instance (plus an aging instance when
//               SDRAM_ARB_AGING_EN is defined) driven from vector tables.
//               Port p presents addr 0xA0000p, wdata 0x100p, wmask p[1:0].
// Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_arbiter_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [3:0]  burst;
    logic        cready;
    logic        rvalid;
    logic [15:0] rdata;
    int          e_port;   // granted port, -1 for none
    logic        e_rd;
    logic        e_wr;
    logic        e_burst;
    logic [3:0]  e_resp;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic [3:0] va, logic [3:0] rd, logic [3:0] wr,
                              logic [3:0] bu, logic cr, logic rv, logic [15:0] rdat,
                              int ep, logic erd, logic ewr, logic ebu,
                              logic [3:0] eresp, logic eerr);
    vec_t v;
    v.valid = va; v.rd = rd; v.wr = wr; v.burst = bu;
    v.cready = cr; v.rvalid = rv; v.rdata = rdat;
    v.e_port = ep; v.e_rd = erd; v.e_wr = ewr; v.e_burst = ebu;
    v.e_resp = eresp; v.e_err = eerr;
    return v;
  endfunction

  // shared drive signals, routed to the selected instance only
  int          sel;
  logic [3:0]  d_valid, d_rd, d_wr, d_burst;
  logic        d_cready, d_rvalid;
  logic [15:0] d_rdata;

  localparam logic [95:0] ADDRS = {24'hA00003, 24'hA00002, 24'hA00001, 24'hA00000};
  localparam logic [63:0] WDATS = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
  localparam logic [7:0]  WMSKS = {2'b11, 2'b10, 2'b01, 2'b00};

  // ---------------- fixed-priority instance ----------------
  sdram_arbiter_n_if #(.NUM_PORTS(4), .ADDR_W(24)) ifx ();
  logic err_fx;
  assign ifx.port_cmd_valid_i = (sel == 0) ? d_valid  : 4'b0;
  assign ifx.port_rd_i        = (sel == 0) ? d_rd     : 4'b0;
  assign ifx.port_wr_i        = (sel == 0) ? d_wr     : 4'b0;
  assign ifx.port_burst_i     = (sel == 0) ? d_burst  : 4'b0;
  assign ifx.sdram_cmd_ready  = (sel == 0) ? d_cready : 1'b0;
  assign ifx.sdram_resp_valid = (sel == 0) ? d_rvalid : 1'b0;
  assign ifx.sdram_rdata      = d_rdata;
  assign ifx.port_addr_x16_i  = ADDRS;
  assign ifx.port_wdata_i     = WDATS;
  assign ifx.port_wmask_i     = WMSKS;

  sdram_arbiter_n #(.NUM_PORTS(4), .ADDR_W(24), .PRIO_MODE(0),
                    .MAX_OUTSTANDING(4), .BURST_LEN(4), .AGE_LIMIT(64)) dut_fx (
    .clk_i(clk), .rst_n_i(rst_n), .bus(ifx.slave), .err_o(err_fx));

  // ---------------- round-robin instance ----------------
  sdram_arbiter_n_if #(.NUM_PORTS(4), .ADDR_W(24)) irr ();
  logic err_rr;
  assign irr.port_cmd_valid_i = (sel == 1) ? d_valid  : 4'b0;
  assign irr.port_rd_i        = (sel == 1) ? d_rd     : 4'b0;
  assign irr.port_wr_i        = (sel == 1) ? d_wr     : 4'b0;
  assign irr.port_burst_i     = (sel == 1) ? d_burst  : 4'b0;
  assign irr.sdram_cmd_ready  = (sel == 1) ? d_cready : 1'b0;
  assign irr.sdram_resp_valid = (sel == 1) ? d_rvalid : 1'b0;
  assign irr.sdram_rdata      = d_rdata;
  assign irr.port_addr_x16_i  = ADDRS;
  assign irr.port_wdata_i     = WDATS;
  assign irr.port_wmask_i     = WMSKS;

  sdram_arbiter_n #(.NUM_PORTS(4), .ADDR_W(24), .PRIO_MODE(1),
                    .MAX_OUTSTANDING(4), .BURST_LEN(4), .AGE_LIMIT(64)) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n), .bus(irr.slave), .err_o(err_rr));

`ifdef SDRAM_ARB_AGING_EN
  // ---------------- aging instance (AGE_LIMIT = 8, fixed) ----------------
  sdram_arbiter_n_if #(.NUM_PORTS(4), .ADDR_W(24)) iag ();
  logic err_ag;
  assign iag.port_cmd_valid_i = (sel == 2) ? d_valid  : 4'b0;
  assign iag.port_rd_i        = (sel == 2) ? d_rd     : 4'b0;
  assign iag.port_wr_i        = (sel == 2) ? d_wr     : 4'b0;
  assign iag.port_burst_i     = (sel == 2) ? d_burst  : 4'b0;
  assign iag.sdram_cmd_ready  = (sel == 2) ? d_cready : 1'b0;
  assign iag.sdram_resp_valid = (sel == 2) ? d_rvalid : 1'b0;
  assign iag.sdram_rdata      = d_rdata;
  assign iag.port_addr_x16_i  = ADDRS;
  assign iag.port_wdata_i     = WDATS;
  assign iag.port_wmask_i     = WMSKS;

  sdram_arbiter_n #(.NUM_PORTS(4), .ADDR_W(24), .PRIO_MODE(0),
                    .MAX_OUTSTANDING(4), .BURST_LEN(4), .AGE_LIMIT(8)) dut_ag (
    .clk_i(clk), .rst_n_i(rst_n), .bus(iag.slave), .err_o(err_ag));
`endif

  // ---------------- sampled outputs of the selected instance ----------------
  logic        s_cvalid, s_rd, s_wr, s_burst, s_err;
  logic [3:0]  s_ready, s_resp;
  logic [23:0] s_addr;
  logic [15:0] s_wdata, s_rdata;
  logic [1:0]  s_wmask;

  always_comb begin
    s_cvalid = ifx.sdram_cmd_valid;  s_rd = ifx.sdram_rd;  s_wr = ifx.sdram_wr;
    s_burst  = ifx.sdram_burst;      s_err = err_fx;       s_ready = ifx.port_cmd_ready_o;
    s_resp   = ifx.port_resp_valid_o; s_addr = ifx.sdram_addr_x16;
    s_wdata  = ifx.sdram_wdata;      s_rdata = ifx.port_rdata_o; s_wmask = ifx.sdram_wmask;
    if (sel == 1) begin
      s_cvalid = irr.sdram_cmd_valid;  s_rd = irr.sdram_rd;  s_wr = irr.sdram_wr;
      s_burst  = irr.sdram_burst;      s_err = err_rr;       s_ready = irr.port_cmd_ready_o;
      s_resp   = irr.port_resp_valid_o; s_addr = irr.sdram_addr_x16;
      s_wdata  = irr.sdram_wdata;      s_rdata = irr.port_rdata_o; s_wmask = irr.sdram_wmask;
    end
`ifdef SDRAM_ARB_AGING_EN
    if (sel == 2) begin
      s_cvalid = iag.sdram_cmd_valid;  s_rd = iag.sdram_rd;  s_wr = iag.sdram_wr;
      s_burst  = iag.sdram_burst;      s_err = err_ag;       s_ready = iag.port_cmd_ready_o;
      s_resp   = iag.port_resp_valid_o; s_addr = iag.sdram_addr_x16;
      s_wdata  = iag.sdram_wdata;      s_rdata = iag.port_rdata_o; s_wmask = iag.sdram_wmask;
    end
`endif
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input int idx, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    d_valid  = v.valid;  d_rd = v.rd;  d_wr = v.wr;  d_burst = v.burst;
    d_cready = v.cready; d_rvalid = v.rvalid; d_rdata = v.rdata;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0]  e_ready;
    logic [23:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_wmask;
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    e_ready = 4'b0;
    e_addr  = 24'h0;
    e_wdata = 16'h0;
    e_wmask = 2'b0;
    if (v.e_port >= 0) begin
      if (v.cready) e_ready[v.e_port] = 1'b1;
      e_addr  = 24'hA00000 + 24'(v.e_port);
      e_wdata = 16'h1000 + 16'(v.e_port);
      e_wmask = 2'(v.e_port);
    end
    chk(idx, "cmd_valid", 32'(s_cvalid), 32'(v.e_port >= 0));
    chk(idx, "ready",     32'(s_ready),  32'(e_ready));
    chk(idx, "addr",      32'(s_addr),   32'(e_addr));
    chk(idx, "wdata",     32'(s_wdata),  32'(e_wdata));
    chk(idx, "wmask",     32'(s_wmask),  32'(e_wmask));
    chk(idx, "sdram_rd",  32'(s_rd),     32'(v.e_rd));
    chk(idx, "sdram_wr",  32'(s_wr),     32'(v.e_wr));
    chk(idx, "burst",     32'(s_burst),  32'(v.e_burst));
    chk(idx, "resp",      32'(s_resp),   32'(v.e_resp));
    chk(idx, "err",       32'(s_err),    32'(v.e_err));
    if (v.rvalid) chk(idx, "rdata", 32'(s_rdata), 32'(v.rdata));
  endtask

  vec_t tfx[$];
  vec_t trr[$];

  initial begin
    rst_n = 1'b0;
    sel   = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 16'h0, -1, 0, 0, 0, 0, 0));

    // ---- fixed-priority table ----
    //          valid    rd       wr       burst  cr rv rdata     port rd wr bu resp   err
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0000, -1, 0, 0, 0, 4'b0000, 0));
    // ports 0 and 2 read together: 0 first, then 2; beats return in order
    tfx.push_back(mk(4'b0101, 4'b0101, 4'b0000, 4'b0000, 1, 0, 16'h0000,  0, 1, 0, 0, 4'b0000, 0));
    tfx.push_back(mk(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1, 0, 16'h0000,  2, 1, 0, 0, 4'b0000, 0));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h1111, -1, 0, 0, 0, 4'b0001, 0));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h2222, -1, 0, 0, 0, 4'b0100, 0));
    // port 1 burst read, four beats, then nothing
    tfx.push_back(mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 16'h0000,  1, 1, 0, 1, 4'b0000, 0));
    for (int k = 0; k < 4; k++)
      tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h00A0 + 16'(k), -1, 0, 0, 0, 4'b0010, 0));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0000, -1, 0, 0, 0, 4'b0000, 0));
    // fill the tag FIFO with 4 reads
    tfx.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 16'h0000,  0, 1, 0, 0, 4'b0000, 0));
    tfx.push_back(mk(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1, 0, 16'h0000,  1, 1, 0, 0, 4'b0000, 0));
    tfx.push_back(mk(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1, 0, 16'h0000,  2, 1, 0, 0, 4'b0000, 0));
    tfx.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 16'h0000,  0, 1, 0, 0, 4'b0000, 0));
    // full: 5th read blocked, concurrent write on port 3 accepted
    tfx.push_back(mk(4'b1001, 4'b0001, 4'b1000, 4'b0000, 1, 0, 16'h0000,  3, 0, 1, 0, 4'b0000, 0));
    tfx.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 16'h0000, -1, 0, 0, 0, 4'b0000, 0));
    // pop in the same cycle does not free a slot for that cycle
    tfx.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 1, 16'h3333, -1, 0, 0, 0, 4'b0001, 0));
    tfx.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 16'h0000,  0, 1, 0, 0, 4'b0000, 0));
    // drain: ports 1, 2, 0, 0
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h0B01, -1, 0, 0, 0, 4'b0010, 0));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h0B02, -1, 0, 0, 0, 4'b0100, 0));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h0B03, -1, 0, 0, 0, 4'b0001, 0));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h0B04, -1, 0, 0, 0, 4'b0001, 0));
    // stray beat with FIFO empty: no strobe, err sticky from next cycle
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'hDEAD, -1, 0, 0, 0, 4'b0000, 0));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0000, -1, 0, 0, 0, 4'b0000, 1));
    // stalled write on port 2 (burst ignored) keeps its grant over port 0
    tfx.push_back(mk(4'b0100, 4'b0000, 4'b0100, 4'b0100, 0, 0, 16'h0000,  2, 0, 1, 0, 4'b0000, 1));
    tfx.push_back(mk(4'b0101, 4'b0000, 4'b0101, 4'b0100, 0, 0, 16'h0000,  2, 0, 1, 0, 4'b0000, 1));
    tfx.push_back(mk(4'b0101, 4'b0000, 4'b0101, 4'b0100, 1, 0, 16'h0000,  2, 0, 1, 0, 4'b0000, 1));
    tfx.push_back(mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 0, 16'h0000,  0, 0, 1, 0, 4'b0000, 1));
    // rd+wr is a read; then push and pop in one cycle
    tfx.push_back(mk(4'b0010, 4'b0010, 4'b0010, 4'b0000, 1, 0, 16'h0000,  1, 1, 0, 0, 4'b0000, 1));
    tfx.push_back(mk(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1, 1, 16'h4444,  2, 1, 0, 0, 4'b0010, 1));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h5555, -1, 0, 0, 0, 4'b0100, 1));
    tfx.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0000, -1, 0, 0, 0, 4'b0000, 1));

    // ---- round-robin table ----
    for (int k = 0; k < 5; k++)
      trr.push_back(mk(4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 0, 16'h0, k % 4, 0, 1, 0, 4'b0000, 0));
    trr.push_back(mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 0, 16'h0, 0, 0, 1, 0, 4'b0000, 0));
    trr.push_back(mk(4'b0101, 4'b0000, 4'b0101, 4'b0000, 1, 0, 16'h0, 2, 0, 1, 0, 4'b0000, 0));
    trr.push_back(mk(4'b0011, 4'b0000, 4'b0011, 4'b0000, 1, 0, 16'h0, 0, 0, 1, 0, 4'b0000, 0));
    trr.push_back(mk(4'b1001, 4'b0000, 4'b1001, 4'b0000, 1, 0, 16'h0, 3, 0, 1, 0, 4'b0000, 0));
    trr.push_back(mk(4'b0110, 4'b0000, 4'b0110, 4'b0000, 0, 0, 16'h0, 1, 0, 1, 0, 4'b0000, 0));
    trr.push_back(mk(4'b0111, 4'b0000, 4'b0111, 4'b0000, 1, 0, 16'h0, 1, 0, 1, 0, 4'b0000, 0));
    trr.push_back(mk(4'b0111, 4'b0000, 4'b0111, 4'b0000, 1, 0, 16'h0, 2, 0, 1, 0, 4'b0000, 0));

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(-1, "rst.cmd_valid", 32'(s_cvalid), 32'd0);
    chk(-1, "rst.ready",     32'(s_ready),  32'd0);
    chk(-1, "rst.resp",      32'(s_resp),   32'd0);
    chk(-1, "rst.err_fx",    32'(err_fx),   32'd0);
    chk(-1, "rst.err_rr",    32'(err_rr),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    sel = 0;
    foreach (tfx[i]) run_vec(tfx[i], i);

    // ---- reset mid-operation discards in-flight tags ----
    run_vec(mk(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1, 0, 16'h0, 1, 1, 0, 0, 4'b0000, 1), 100);
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 16'h0, -1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk(101, "midrst.err", 32'(s_err), 32'd0);
    run_vec(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'hBEEF, -1, 0, 0, 0, 4'b0000, 0), 102);
    run_vec(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0000, -1, 0, 0, 0, 4'b0000, 1), 103);

    // ---- round-robin instance ----
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 16'h0, -1, 0, 0, 0, 0, 0));
    sel = 1;
    foreach (trr[i]) run_vec(trr[i], 300 + i);

`ifdef SDRAM_ARB_AGING_EN
    // ---- aging: port 3 wins on its 9th waiting cycle over port 0 ----
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 16'h0, -1, 0, 0, 0, 0, 0));
    sel = 2;
    for (int k = 0; k < 10; k++)
      run_vec(mk(4'b1001, 4'b0000, 4'b1001, 4'b0000, 1, 0, 16'h0,
                 (k == 8) ? 3 : 0, 0, 1, 0, 4'b0000, 0), 400 + k);
`endif

    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 16'h0, -1, 0, 0, 0, 0, 0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
